io_rle_loader: RTL and testbench
================================

# io_rle_loader

Receives the run-length-compressed CNN weight stream and image stream pushed 16 bits at a time by the GPU driver and paces that driver with `done`. It expands each run into a bitstream, packs the bits LSB-first into 16-bit words, and writes them into the accelerator's on-chip memory. The CNN stream goes to the CNN region and the image stream goes to the image region. A final interrupt with `load=0` ends loading and starts processing.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `CNN_BASE`, 16'h0000: first word address of the CNN region.
- `IMG_BASE`, 16'h4000: first word address of the image region.
- `REGION_WORDS`, 16'h4000: capacity of each region, in words.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `interrupt`  in  1  command strobe, sampled on posedge.
- `load`  in  1  at interrupt: 1 = start a stream, 0 = loading finished.
- `cnn`  in  1  at interrupt with `load=1`: 1 = CNN stream, 0 = image stream.
- `data`  in  16  compressed word; bit15 = run value, bits14:0 = run length L.
- `done`  out  1  request for the next compressed word.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory write address.
- `mem_wdata`  out  16  packed decoded bits.
- `busy`  out  1  stream active (state ≠ IDLE).
- `overflow`  out  1  sticky; a write was dropped because the region was full.
- `process_start`  out  1  one-cycle pulse at the end of loading.

## Operation
- States: IDLE, REQ, RUN, FLUSH, START.
- IDLE:
  - interrupt with `load=1`: select base (`cnn ? CNN_BASE : IMG_BASE`), clear the word count, bit index and packer, clear `overflow`, go to REQ.
  - interrupt with `load=0`: go to START.
- REQ: `done=1` for exactly one cycle, then go to RUN; the word is captured on the next posedge.
- RUN:
  - First cycle: latch `data` as {value, L}.
  - L=0: the word is a no-op; go straight back to REQ.
  - Otherwise emit one bit per cycle, L cycles in total, then go back to REQ.
- Packer: bit k of the current word = k-th emitted bit; after bit 15 is emitted, write the word (`mem_we=1`) at base+count, then count+1 and the packer clears.
- Interrupt while in REQ or RUN: abort the rest of the current run and go to FLUSH. A word captured in the same cycle as the interrupt is discarded; interrupt wins.
- FLUSH:
  - bit index ≠ 0: write the partial word with the upper bits zero, for one cycle.
  - Then act on the latched `load`/`cnn` exactly as IDLE does: start a new stream, or go to START.
- START: `process_start=1` for one cycle, then IDLE.
- Region full (count = REGION_WORDS): suppress the write, set `overflow`, keep decoding; the address does not wrap.
- Interrupt while in FLUSH or START: ignored.
- Interrupt in IDLE with no stream started and `load=0`: still pulses `process_start`.

## Timing
- Reset values: `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `overflow`=0, `process_start`=0; state IDLE, all counters 0.
- `rst` mid-stream discards everything with no flush.
- All outputs are registered.
- The driver samples `done` and updates `data` on negedge. So:
  - `done` high at posedge t means `data` is valid at posedge t+1.
  - `done` is low from t+1 onward.
- First `done` comes 1 cycle after the accepting interrupt edge.
- Word spacing on `done`: 1 + max(L,1) cycles for a non-zero run; 2 cycles for L=0.
- `mem_we` comes 1 cycle after the 16th bit of a word; at most one write per cycle.
- End of loading: `process_start` is 1 cycle after FLUSH (2 cycles after the interrupt if nothing to flush).

## Structure
- Package `io_pkg`: state enum, `RUN_VAL_BIT`=15, `RUN_LEN_W`=15, default base/size constants.
- Sub-module `bit_packer`: takes a serial bit plus a flush request; produces a 16-bit word, a valid strobe and a bit index.
- The FSM, address counter and region logic stay in `io_rle_loader`.

## Test plan
- Reset, then interrupt with `load=1`, `cnn=1`:
  - `done` pulses one cycle later.
  - Words 0x8010 then 0x0010 → one write to `mem_addr`=0x0000 with `mem_wdata`=0xFFFF, then one with 0x0000.
- Image stream (`cnn=0`), word 0x8005, then interrupt with `load=0` → partial write at 0x4000 with `mem_wdata`=0x001F, then `process_start` pulse.
- Word 0x0000 mid-stream → no write; next `done` comes 2 cycles after the previous one.
- Interrupt arriving in RUN with 3 bits left of an L=10 run of 1s → flush writes 0x007F (7 ones), then the new stream starts at the new base.
- REGION_WORDS=2 and 48 ones sent → exactly 2 writes, `overflow`=1, `done` keeps pulsing.
- `rst` asserted during RUN → all outputs 0 the next cycle, no write, state IDLE.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and constants for the RLE weight/image loader.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RUN,
        FLUSH,
        START
    } state_t;

    localparam int WORD_W      = 16;
    localparam int IDX_W       = $clog2(WORD_W);
    localparam int RUN_VAL_BIT = 15;
    localparam int RUN_LEN_W   = 15;

    localparam logic [15:0] DEF_CNN_BASE     = 16'h0000;
    localparam logic [15:0] DEF_IMG_BASE     = 16'h4000;
    localparam logic [15:0] DEF_REGION_WORDS = 16'h4000;

endpackage

// File: rtl/io_rle_loader_if.sv
// Driver-side command/data handshake plus the memory write port.
interface io_rle_loader_if
    import io_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              interrupt;
    logic              load;
    logic              cnn;
    logic [WORD_W-1:0] data;
    logic              done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              busy;
    logic              overflow;
    logic              process_start;

    modport master (
        output interrupt, load, cnn, data,
        input  done, mem_we, mem_addr, mem_wdata, busy, overflow, process_start
    );

    modport slave (
        input  interrupt, load, cnn, data,
        output done, mem_we, mem_addr, mem_wdata, busy, overflow, process_start
    );
endinterface

// File: rtl/io_rle_loader_bit_packer.sv
// Serial-to-parallel packer: bit k of a word is the k-th pushed bit (LSB first).
module bit_packer
    import io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              bit_in,
    input  logic              flush,
    input  logic              hold,
    output logic [WORD_W-1:0] word,
    output logic              valid,
    output logic [IDX_W-1:0]  bit_idx,
    output logic              complete
);
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shift_next;
    logic [WORD_W-1:0] word_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              valid_reg;

    // Drop the incoming bit into its slot; all other slots keep their value.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_slot
        assign shift_next[gi] = (push && idx_reg == IDX_W'(gi)) ? bit_in : shift_reg[gi];
    end

    // A word completes on its last bit, or on a flush that has something pending.
    assign complete = (push && idx_reg == IDX_W'(WORD_W - 1)) || (flush && idx_reg != '0);

    // Shift/index state; the completed word is held as the write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            idx_reg   <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            shift_reg <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= complete && !hold;
            if (complete && !hold) begin
                word_reg <= shift_next;
            end
            if (complete || flush) begin
                shift_reg <= '0;
                idx_reg   <= '0;
            end else if (push) begin
                shift_reg <= shift_next;
                idx_reg   <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign word    = word_reg;
    assign valid   = valid_reg;
    assign bit_idx = idx_reg;
endmodule

// File: rtl/io_rle_loader.sv
// Run-length decoder that expands driver words into packed bits in on-chip memory.
module io_rle_loader
    import io_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] CNN_BASE     = ADDR_W'(DEF_CNN_BASE),
    parameter logic [ADDR_W-1:0] IMG_BASE     = ADDR_W'(DEF_IMG_BASE),
    parameter logic [ADDR_W-1:0] REGION_WORDS = ADDR_W'(DEF_REGION_WORDS)
) (
    input logic           clk,
    input logic           rst,
    io_rle_loader_if.slave bus
);
    state_t                state_reg, state_next;
    logic                  val_reg, val_next;
    logic [RUN_LEN_W-1:0]  rem_reg, rem_next;
    logic [ADDR_W-1:0]     base_reg, base_next;
    logic [ADDR_W-1:0]     count_reg, count_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic                  overflow_reg, overflow_next;
    logic                  load_lat_reg, load_lat_next;
    logic                  cnn_lat_reg, cnn_lat_next;
    logic                  done_reg, busy_reg, start_pulse_reg;

    logic                  push, flush, clear, abort, start, start_cnn, full;
    logic [WORD_W-1:0]     pk_word;
    logic                  pk_valid, pk_complete;
    logic [IDX_W-1:0]      pk_idx;

    // Once the region is full further words are decoded but never written.
    assign full = (count_reg == REGION_WORDS);

    bit_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .bit_in   (val_reg),
        .flush    (flush),
        .hold     (full),
        .word     (pk_word),
        .valid    (pk_valid),
        .bit_idx  (pk_idx),
        .complete (pk_complete)
    );

    // Next-state, run countdown, stream setup and region bookkeeping.
    always_comb begin
        state_next    = state_reg;
        val_next      = val_reg;
        rem_next      = rem_reg;
        base_next     = base_reg;
        count_next    = count_reg;
        addr_next     = addr_reg;
        overflow_next = overflow_reg;
        load_lat_next = load_lat_reg;
        cnn_lat_next  = cnn_lat_reg;
        push          = 1'b0;
        abort         = 1'b0;
        start         = 1'b0;
        start_cnn     = bus.cnn;
        case (state_reg)
            IDLE: begin
                if (bus.interrupt) begin
                    if (bus.load) start = 1'b1;
                    else          state_next = START;
                end
            end
            REQ: begin
                // An interrupt here discards the word being delivered.
                if (bus.interrupt) begin
                    abort = 1'b1;
                end else begin
                    state_next = RUN;
                    val_next   = bus.data[RUN_VAL_BIT];
                    rem_next   = bus.data[RUN_LEN_W-1:0];
                end
            end
            RUN: begin
                if (bus.interrupt) begin
                    abort = 1'b1;
                end else if (rem_reg == '0) begin
                    state_next = REQ;
                end else begin
                    push     = 1'b1;
                    rem_next = rem_reg - RUN_LEN_W'(1);
                    if (rem_reg == RUN_LEN_W'(1)) state_next = REQ;
                end
            end
            FLUSH: begin
                start_cnn = cnn_lat_reg;
                if (load_lat_reg) start = 1'b1;
                else              state_next = START;
            end
            START:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            load_lat_next = bus.load;
            cnn_lat_next  = bus.cnn;
            state_next    = FLUSH;
        end
        if (start) begin
            base_next     = start_cnn ? CNN_BASE : IMG_BASE;
            count_next    = '0;
            overflow_next = 1'b0;
            state_next    = REQ;
        end
        if (pk_complete) begin
            if (full) begin
                overflow_next = 1'b1;
            end else begin
                addr_next  = base_reg + count_reg;
                count_next = count_reg + ADDR_W'(1);
            end
        end
    end

    assign clear = start;
    assign flush = abort && (pk_idx != '0);

    // State and datapath registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            val_reg         <= 1'b0;
            rem_reg         <= '0;
            base_reg        <= '0;
            count_reg       <= '0;
            addr_reg        <= '0;
            overflow_reg    <= 1'b0;
            load_lat_reg    <= 1'b0;
            cnn_lat_reg     <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            start_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            val_reg         <= val_next;
            rem_reg         <= rem_next;
            base_reg        <= base_next;
            count_reg       <= count_next;
            addr_reg        <= addr_next;
            overflow_reg    <= overflow_next;
            load_lat_reg    <= load_lat_next;
            cnn_lat_reg     <= cnn_lat_next;
            done_reg        <= (state_next == REQ);
            busy_reg        <= (state_next != IDLE);
            start_pulse_reg <= (state_next == START);
        end
    end

    assign bus.done          = done_reg;
    assign bus.busy          = busy_reg;
    assign bus.process_start = start_pulse_reg;
    assign bus.overflow      = overflow_reg;
    assign bus.mem_we        = pk_valid;
    assign bus.mem_addr      = addr_reg;
    assign bus.mem_wdata     = pk_word;
endmodule

// File: tb/tb_io_rle_loader.sv
// Bench for io_rle_loader: behaves like the GPU driver and checks writes against a bitstream model.
module tb_io_rle_loader;
    import io_pkg::*;

    localparam int          RW = 2;
    localparam logic [15:0] CB = 16'h0000;
    localparam logic [15:0] IB = 16'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] wr_q[$];
    logic [31:0] exp_q[$];
    bit          bits_q[$];
    int          last_nwords = 0;

    io_rle_loader_if #(.ADDR_W(16)) bus();

    io_rle_loader #(
        .ADDR_W      (16),
        .CNN_BASE    (CB),
        .IMG_BASE    (IB),
        .REGION_WORDS(16'(RW))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write seen away from the clock edge.
    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: expand a compressed word into its run of bits.
    function automatic void add_word(input logic [15:0] w);
        for (int k = 0; k < int'(w[14:0]); k++) bits_q.push_back(w[15]);
    endfunction

    // Reference: pack the stream's bits LSB-first, region-limited, into expected writes.
    function automatic void model_append(input logic is_cnn);
        int nwords;
        logic [15:0] w;
        nwords = (bits_q.size() + 15) / 16;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            for (int k = 0; k < 16; k++)
                if (16 * i + k < bits_q.size()) w[k] = bits_q[16 * i + k];
            if (i < RW) exp_q.push_back({(is_cnn ? CB : IB) + 16'(i), w});
        end
        last_nwords = nwords;
    endfunction

    task automatic start_cmd(input logic ld, input logic c);
        bus.interrupt = 1'b1;
        bus.load      = ld;
        bus.cnn       = c;
        @(negedge clk);
        bus.interrupt = 1'b0;
        if (ld) check_eq("first_done", bus.done, 1'b1);
    endtask

    // Serve words on each done, then end the stream with an interrupt on the next request.
    task automatic feed(input logic [15:0] words[$], input logic end_load, input logic end_cnn);
        int idx = 0;
        int last = -1;
        int exp_gap = 0;
        int budget = 3000;
        int nbits = 0;
        bit finished = 0;
        foreach (words[i]) nbits += int'(words[i][14:0]);
        while (!finished && budget > 0) begin
            if (bus.done) begin
                if (last >= 0) check_eq("done_gap", cyc - last, exp_gap);
                last = cyc;
                if (idx < words.size()) begin
                    bus.data = words[idx];
                    exp_gap  = 1 + ((words[idx][14:0] == 15'd0) ? 1 : int'(words[idx][14:0]));
                    idx++;
                end else begin
                    check_eq("ovf_before_end", bus.overflow, ((nbits / 16) > RW) ? 1 : 0);
                    bus.interrupt = 1'b1;
                    bus.load      = end_load;
                    bus.cnn       = end_cnn;
                    finished      = 1;
                end
            end
            @(negedge clk);
            bus.interrupt = 1'b0;
            budget--;
        end
        check_eq("feed_finished", finished, 1'b1);
    endtask

    task automatic expect_end();
        @(negedge clk);
        check_eq("process_start", bus.process_start, 1'b1);
        check_eq("ovf_at_end", bus.overflow, (last_nwords > RW) ? 1 : 0);
        @(negedge clk);
        check_eq("process_start_len", bus.process_start, 1'b0);
        check_eq("busy_idle", bus.busy, 1'b0);
    endtask

    task automatic check_writes(input int mark);
        check_eq("wr_count", wr_q.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size() && mark + i < wr_q.size(); i++)
            check_eq("wr_addr_data", wr_q[mark + i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, ns, n, dcnt;
        logic [15:0] w;
        logic [15:0] wq[$];
        logic cnn_s[3];

        bus.interrupt = 1'b0;
        bus.load      = 1'b0;
        bus.cnn       = 1'b0;
        bus.data      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_we", bus.mem_we, 1'b0);
        check_eq("rst_addr", bus.mem_addr, 16'h0);
        check_eq("rst_wdata", bus.mem_wdata, 16'h0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_ovf", bus.overflow, 1'b0);
        check_eq("rst_ps", bus.process_start, 1'b0);

        // CNN stream 0x8010,0x0010 chained into image stream 0x8005, then end.
        mark = wr_q.size();
        start_cmd(1'b1, 1'b1);
        wq = '{16'h8010, 16'h0010};
        bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(1'b1);
        feed(wq, 1'b1, 1'b0);
        wq = '{16'h8005};
        bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(1'b0);
        feed(wq, 1'b0, 1'b0);
        expect_end();
        check_writes(mark);

        // Zero-length words in the middle of a stream.
        mark = wr_q.size();
        start_cmd(1'b1, 1'b1);
        wq = '{16'h8003, 16'h0000, 16'h8002, 16'h0000};
        bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(1'b1);
        feed(wq, 1'b0, 1'b0);
        expect_end();
        check_writes(mark);

        // Abort an L=10 run of ones with 3 bits left, restart at the CNN base.
        mark = wr_q.size();
        start_cmd(1'b1, 1'b0);
        bus.data = 16'h800A;
        repeat (8) @(negedge clk);
        bus.interrupt = 1'b1;
        bus.load      = 1'b1;
        bus.cnn       = 1'b1;
        @(negedge clk);
        bus.interrupt = 1'b0;
        check_eq("abort_flush_we", bus.mem_we, 1'b1);
        bits_q.delete(); repeat (7) bits_q.push_back(1'b1); model_append(1'b0);
        wq = '{16'h8010};
        bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(1'b1);
        feed(wq, 1'b0, 1'b0);
        expect_end();
        check_writes(mark);

        // 48 ones into a 2-word region.
        mark = wr_q.size();
        start_cmd(1'b1, 1'b1);
        wq = '{16'h8010, 16'h8010, 16'h8010};
        bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(1'b1);
        feed(wq, 1'b0, 1'b0);
        expect_end();
        check_writes(mark);

        // End-of-load with no stream started.
        mark = wr_q.size();
        start_cmd(1'b0, 1'b0);
        check_eq("idle_ps", bus.process_start, 1'b1);
        @(negedge clk);
        check_eq("idle_ps_len", bus.process_start, 1'b0);
        check_writes(mark);

        // Reset in the middle of a run.
        mark = wr_q.size();
        start_cmd(1'b1, 1'b1);
        bus.data = 16'h8020;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_done", bus.done, 1'b0);
        check_eq("mid_rst_we", bus.mem_we, 1'b0);
        check_eq("mid_rst_addr", bus.mem_addr, 16'h0);
        check_eq("mid_rst_wdata", bus.mem_wdata, 16'h0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_ovf", bus.overflow, 1'b0);
        check_eq("mid_rst_ps", bus.process_start, 1'b0);
        rst = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check_eq("idle_after_rst", dcnt, 0);
        check_eq("rst_no_write", wr_q.size() - mark, 0);

        // Randomized chains of streams.
        for (int it = 0; it < 12; it++) begin
            mark = wr_q.size();
            ns = $urandom_range(1, 3);
            for (int s = 0; s < 3; s++) cnn_s[s] = 1'($urandom_range(0, 1));
            start_cmd(1'b1, cnn_s[0]);
            for (int s = 0; s < ns; s++) begin
                wq.delete();
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) begin
                    w = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 40))};
                    wq.push_back(w);
                end
                bits_q.delete(); foreach (wq[j]) add_word(wq[j]); model_append(cnn_s[s]);
                feed(wq, (s < ns - 1) ? 1'b1 : 1'b0, (s < ns - 1) ? cnn_s[s + 1] : 1'b0);
            end
            expect_end();
            check_writes(mark);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
